// File: rtl/irq_timer.sv
// irq_timer: 16-bit prescaled down-counter with an active-low IRQ on the 6502 bus (option: IRQ_TIMER_SNAPSHOT_EN)
module irq_timer #(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int          PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  odata,
  input  logic        rw,
  input  logic        clk2,
  output logic        sel,
  output logic [7:0]  rdata,
  output logic        irq
);
  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
  logic        clk2_q;
  logic [7:0]  pre;
  logic [15:0] counter;
  logic [15:0] reload;
  logic [7:0]  reload_lo;
  logic        en;
  logic        ie;
  logic        oneshot;
  logic        pend;
  logic [7:0]  hi_rd;
  logic        bus_ev;
  logic        wr;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        tick;
  logic        under;
  assign sel     = addr[15:2] == BASE[15:2];
  assign bus_ev  = clk2_q & ~clk2;
  assign wr      = bus_ev & sel & ~rw;
  assign wr_lo   = wr & (addr[1:0] == 2'd0);
  assign wr_hi   = wr & (addr[1:0] == 2'd1);
  assign wr_ctrl = wr & (addr[1:0] == 2'd2);
  assign wr_stat = wr & (addr[1:0] == 2'd3);
  // a CNT_HI write or a CTRL write that clears EN swallows a coincident tick
  assign tick    = en & (pre == PRE_MAX) & ~wr_hi & ~(wr_ctrl & ~odata[0]);
  assign under   = tick & (counter == 16'd0);
  // phi2 history for falling-edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) clk2_q <= 1'b0;
    else clk2_q <= clk2;
  // prescaler: free-runs only while enabled, restarts on a counter load
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre <= 8'd0;
    else if (!en || wr_hi || pre == PRE_MAX) pre <= 8'd0;
    else pre <= pre + 8'd1;
  // reload registers: low byte is staged until the high byte arrives
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reload_lo <= 8'd0;
      reload    <= 16'd0;
    end else begin
      if (wr_lo) reload_lo <= odata;
      if (wr_hi) reload <= {odata, reload_lo};
    end
  // down-counter: load beats tick, underflow reloads or parks at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) counter <= 16'd0;
    else if (wr_hi) counter <= {odata, reload_lo};
    else if (under) counter <= oneshot ? 16'd0 : reload;
    else if (tick) counter <= counter - 16'd1;
  // control bits; a one-shot underflow drops EN by itself
  always_ff @(posedge clk or negedge reset)
    if (!reset) {oneshot, ie, en} <= 3'd0;
    else if (wr_ctrl) {oneshot, ie, en} <= odata[2:0];
    else if (under && oneshot) en <= 1'b0;
  // pending flag: an underflow set outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) pend <= 1'b0;
    else if (under) pend <= 1'b1;
    else if (wr_stat && odata[7]) pend <= 1'b0;
  // registered active-low request so the CPU never sees a glitch
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq <= 1'b1;
    else irq <= ~(pend & ie);
`ifdef IRQ_TIMER_SNAPSHOT_EN
  logic [7:0] hi_snap;
  // latch the high byte when the low byte is read so 16-bit reads are coherent
  always_ff @(posedge clk or negedge reset)
    if (!reset) hi_snap <= 8'd0;
    else if (bus_ev && sel && rw && addr[1:0] == 2'd0) hi_snap <= counter[15:8];
  assign hi_rd = hi_snap;
`else
  assign hi_rd = counter[15:8];
`endif
  // register read mux
  always_comb
    rdata = addr[1:0] == 2'd0 ? counter[7:0] :
            addr[1:0] == 2'd1 ? hi_rd :
            addr[1:0] == 2'd2 ? {5'd0, oneshot, ie, en} : {pend, 7'd0};
endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: vector table plus timed sequences for irq_timer, scoreboard-checked
module tb_irq_timer;
`ifdef IRQ_TIMER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  odata = 8'h00;
  logic        rw = 1'b1;
  logic        clk2 = 1'b0;
  logic        sel;
  logic [7:0]  rdata;
  logic        irq;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  irq_timer #(.BASE(16'hD000), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .odata(odata), .rw(rw),
    .clk2(clk2), .sel(sel), .rdata(rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { string n; logic [15:0] v; } exp_t;
  exp_t sb[$];
  typedef struct { logic [15:0] a; logic w; logic [7:0] d; logic [9:0] e; string n; } vec_t;
  vec_t vt[$];
  task automatic push(input string n, input logic [15:0] v);
    sb.push_back('{n, v});
  endtask
  task automatic pop_check(input logic [15:0] act);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard-empty: got %h with nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.n, act, e.v);
      end
    end
  endtask
  task automatic rd_chk(input logic [15:0] a, input logic s, input logic i, input logic [7:0] d, input string n);
    addr = a;
    push(n, {6'd0, s, i, d});
    #1;
    pop_check({6'd0, sel, irq, rdata});
  endtask
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; odata = d; rw = 1'b0; clk2 = 1'b1;
    @(negedge clk);
    clk2 = 1'b0;
    @(posedge clk);
    #1;
    rw = 1'b1;
  endtask
  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rw = 1'b1; clk2 = 1'b1;
    @(negedge clk);
    clk2 = 1'b0;
    d = rdata;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_pend(output int t);
    addr = 16'hD003;
    t = -1000;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rdata[7]) begin
        t = cyc;
        return;
      end
    end
  endtask
  task automatic add(input logic [15:0] a, input logic w, input logic [7:0] d, input logic [9:0] e, input string n);
    vt.push_back('{a, w, d, e, n});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, t1, t2, t3;
    logic [7:0] lo;
    add(16'hD000, 0, 8'h00, {2'b11, 8'h00}, "rst_cnt_lo");
    add(16'hD001, 0, 8'h00, {2'b11, 8'h00}, "rst_cnt_hi");
    add(16'hD002, 0, 8'h00, {2'b11, 8'h00}, "rst_ctrl");
    add(16'hD003, 0, 8'h00, {2'b11, 8'h00}, "rst_stat");
    add(16'h0000, 0, 8'h00, {2'b01, 8'h00}, "sel_0000");
    add(16'hD004, 0, 8'h00, {2'b01, 8'h00}, "sel_d004");
    add(16'hCFFF, 0, 8'h00, {2'b01, 8'h00}, "sel_cfff");
    add(16'hD002, 1, 8'hF8, 10'd0, "");
    add(16'hD002, 0, 8'h00, {2'b11, 8'h00}, "ctrl_hi_bits_zero");
    add(16'hD002, 1, 8'h06, 10'd0, "");
    add(16'hD002, 0, 8'h00, {2'b11, 8'h06}, "ctrl_readback");
    add(16'hD000, 1, 8'h34, 10'd0, "");
    add(16'hD000, 0, 8'h00, {2'b11, 8'h00}, "lo_write_staged");
    add(16'hD001, 1, 8'h12, 10'd0, "");
    add(16'hD000, 0, 8'h00, {2'b11, 8'h34}, "load_lo");
    add(16'hD001, 0, 8'h00, {2'b11, SNAP ? 8'h00 : 8'h12}, "load_hi");
    add(16'hD002, 1, 8'h00, 10'd0, "");
    add(16'hD003, 1, 8'h80, 10'd0, "");
    add(16'hD003, 0, 8'h00, {2'b11, 8'h00}, "stat_idle");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    foreach (vt[k]) begin
      if (vt[k].w) bus_wr(vt[k].a, vt[k].d);
      else begin
        @(negedge clk);
        rd_chk(vt[k].a, vt[k].e[9], vt[k].e[8], vt[k].e[7:0], vt[k].n);
      end
    end
    // periodic: reload 3, prescale 4 -> 16 clocks to underflow
    bus_wr(16'hD000, 8'h03);
    bus_wr(16'hD001, 8'h00);
    bus_wr(16'hD002, 8'h03);
    t0 = cyc;
    push("period_first", 16'd16);
    wait_pend(t1);
    pop_check(16'(t1 - t0));
    rd_chk(16'hD003, 1, 1, 8'h80, "irq_not_yet");
    @(posedge clk);
    #1;
    rd_chk(16'hD003, 1, 0, 8'h80, "irq_fall");
    rd_chk(16'hD000, 1, 0, 8'h03, "reloaded_lo");
    rd_chk(16'hD001, 1, 0, 8'h00, "reloaded_hi");
    bus_wr(16'hD003, 8'h80);
    rd_chk(16'hD003, 1, 0, 8'h00, "clear_pend");
    @(posedge clk);
    #1;
    rd_chk(16'hD003, 1, 1, 8'h00, "irq_rise");
    push("period_next", 16'd16);
    wait_pend(t2);
    pop_check(16'(t2 - t1));
    // clear, then land a second clear exactly on the next underflow
    bus_wr(16'hD003, 8'h80);
    t3 = t2 + 16;
    while (cyc < t3 - 2) begin
      @(posedge clk);
      #1;
    end
    bus_wr(16'hD003, 8'h80);
    push("collide_edge", 16'(t3));
    pop_check(16'(cyc));
    rd_chk(16'hD003, 1, 1, 8'h80, "set_beats_clear");
    @(posedge clk);
    #1;
    rd_chk(16'hD003, 1, 0, 8'h80, "set_beats_clear_irq");
    // reset in the middle of a count
    #2 reset = 1'b0;
    #1;
    rd_chk(16'hD003, 1, 1, 8'h00, "midreset_stat");
    rd_chk(16'hD002, 1, 1, 8'h00, "midreset_ctrl");
    @(negedge clk);
    reset = 1'b1;
    // one-shot: reload 2 -> 12 clocks, then parked
    bus_wr(16'hD000, 8'h02);
    bus_wr(16'hD001, 8'h00);
    bus_wr(16'hD002, 8'h07);
    t0 = cyc;
    push("oneshot_time", 16'd12);
    wait_pend(t1);
    pop_check(16'(t1 - t0));
    repeat (20) @(posedge clk);
    #1;
    rd_chk(16'hD002, 1, 0, 8'h06, "oneshot_en_off");
    rd_chk(16'hD000, 1, 0, 8'h00, "oneshot_lo");
    rd_chk(16'hD001, 1, 0, 8'h00, "oneshot_hi");
    bus_wr(16'hD003, 8'h80);
    repeat (30) @(posedge clk);
    #1;
    rd_chk(16'hD003, 1, 1, 8'h00, "oneshot_single");
    // coherent read across 0100 -> 00FF
    bus_wr(16'hD002, 8'h00);
    bus_wr(16'hD000, 8'h00);
    bus_wr(16'hD001, 8'h01);
    bus_wr(16'hD002, 8'h01);
    bus_rd(16'hD000, lo);
    push("snap_lo", 16'h0000);
    pop_check({8'd0, lo});
    repeat (3) @(posedge clk);
    #1;
    rd_chk(16'hD001, 1, 1, SNAP ? 8'h01 : 8'h00, "snap_hi");
    rd_chk(16'hD000, 1, 1, 8'hFF, "live_lo");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
